// File: rtl/wishbone_slave_mem.sv
// Wishbone single-cycle responder over an internal byte array, with fixed wait
// states before ack and a one-byte-per-cycle clear sweep (also run out of reset).
//
// state  | meaning
// IDLE   | ready; accepts cyc_i&stb_i, else starts a requested clear
// WAIT   | request latched, counting down wait states; cyc_i low aborts
// ACK    | ack_o high; write committed / read data presented on dat_o
// CLEAR  | writing INIT_VALUE to one byte per cycle, bus stalled
module wishbone_slave_mem #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [7:0]  INIT_VALUE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic       clear_done,
  input  logic [7:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  input  logic       we_i,
  input  logic       stb_i,
  input  logic       cyc_i,
  output logic       ack_o,
  output logic       stall_o
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAST_PTR = 8'(DEPTH - 1);
  localparam logic [3:0] WS       = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] ptr;
  logic [7:0] adr_q;
  logic [7:0] dat_q;
  logic       we_q;
  logic       clear_pend;
  logic [7:0] mem [DEPTH];

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < 9'(DEPTH);
  endfunction

  // Addresses beyond DEPTH read as zero rather than aliasing.
  function automatic logic [7:0] rd_byte(input logic [7:0] a);
    return in_range(a) ? mem[a[AW-1:0]] : 8'h00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      ptr        <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      clear_pend <= 1'b0;
      dat_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cyc_i && stb_i) begin
            adr_q <= adr_i;
            dat_q <= dat_i;
            we_q  <= we_i;
            if (clear_req) clear_pend <= 1'b1;
            if (WS != 4'd0) begin
              cnt   <= WS;
              state <= S_WAIT;
            end else begin
              state <= S_ACK;
              if (!we_i) dat_o <= rd_byte(adr_i);
            end
          end else if (clear_req || clear_pend) begin
            ptr   <= '0;
            state <= S_CLEAR;
          end
        end
        S_WAIT: begin
          if (clear_req) clear_pend <= 1'b1;
          if (!cyc_i) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state <= S_ACK;
            if (!we_q) dat_o <= rd_byte(adr_q);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (clear_req) clear_pend <= 1'b1;
          state <= S_IDLE;
        end
        S_CLEAR: begin
          if (ptr == LAST_PTR) begin
            ptr        <= '0;
            clear_pend <= 1'b0;
            state      <= S_IDLE;
          end else begin
            ptr <= ptr + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset of its own; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)
        mem[ptr[AW-1:0]] <= INIT_VALUE;
      else if (state == S_ACK && we_q && in_range(adr_q))
        mem[adr_q[AW-1:0]] <= dat_q;
    end
  end

  assign ack_o      = (state == S_ACK);
  assign stall_o    = (state == S_WAIT) || (state == S_CLEAR);
  assign clear_busy = (state == S_CLEAR);
  assign clear_done = (state == S_CLEAR) && (ptr == LAST_PTR);

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Directed bench: DUT A (256 bytes, 1 wait state) and DUT B (128 bytes, 3 wait
// states) share the bus inputs; each check targets one DUT's outputs.
module tb_wishbone_slave_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic [7:0] adr_i, dat_i;
  logic       we_i, stb_i, cyc_i;

  logic       busy_a, done_a, ack_a, stall_a;
  logic [7:0] dat_a;
  logic       busy_b, done_b, ack_b, stall_b;
  logic [7:0] dat_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wishbone_slave_mem #(.DEPTH(256), .WAIT_STATES(1), .INIT_VALUE(8'h00)) u_dut_a (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(busy_a), .clear_done(done_a),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_a), .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i),
    .ack_o(ack_a), .stall_o(stall_a));

  wishbone_slave_mem #(.DEPTH(128), .WAIT_STATES(3), .INIT_VALUE(8'h00)) u_dut_b (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(busy_b), .clear_done(done_b),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_b), .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i),
    .ack_o(ack_b), .stall_o(stall_b));

  typedef struct {
    bit         which;
    bit         we;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; returns likewise.
  task automatic txn(input bit which, input bit we, input logic [7:0] adr, input logic [7:0] dat,
                     input bit clr, input int budget,
                     output logic [7:0] rdat, output int lat, output bit stall_ok, output bit extra);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; clear_req = clr;
    lat = 0; stall_ok = 1'b1; extra = 1'b0; rdat = 8'hxx;
    forever begin
      tick();
      clear_req = 1'b0;
      lat++;
      if (which ? ack_b : ack_a) break;
      if (!(which ? stall_b : stall_a)) stall_ok = 1'b0;
      if (lat >= budget) begin
        lat = -1;
        break;
      end
    end
    rdat = which ? dat_b : dat_a;
    tick();
    if (which ? ack_b : ack_a) extra = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick();
    if (which ? ack_b : ack_a) extra = 1'b1;
  endtask

  task automatic sweep_check(output int busy_n, output int done_n);
    busy_n = 0; done_n = 0;
    while (busy_a && busy_n < 400) begin
      busy_n++;
      if (done_a) done_n++;
      tick();
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] last_rd [2];
    int         lat, nb, nd;
    bit         st_ok, extra, ack_seen;

    rst = 1'b1; clear_req = 1'b0; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;

    vecs.push_back('{0, 0, 8'h00, 8'h00, 8'h00, 2});
    vecs.push_back('{0, 0, 8'hFF, 8'h00, 8'h00, 2});
    vecs.push_back('{0, 1, 8'h12, 8'h3C, 8'h00, 2});
    vecs.push_back('{0, 0, 8'h12, 8'h00, 8'h3C, 2});
    for (int i = 0; i < 8; i++) vecs.push_back('{0, 1, 8'(i), 8'hA5, 8'h00, 2});
    for (int i = 0; i < 8; i++) vecs.push_back('{0, 0, 8'(i), 8'h00, 8'hA5, 2});
    vecs.push_back('{1, 1, 8'h90, 8'h77, 8'h00, 4});
    vecs.push_back('{1, 0, 8'h90, 8'h00, 8'h00, 4});
    vecs.push_back('{1, 1, 8'h40, 8'h33, 8'h00, 4});
    vecs.push_back('{1, 0, 8'h40, 8'h00, 8'h33, 4});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_a, 0);
    chk("rst_stall", stall_a, 1);
    chk("rst_dat", dat_a, 8'h00);
    chk("rst_busy", busy_a, 1);
    chk("rst_done", done_a, 0);
    rst = 1'b0;
    sweep_check(nb, nd);
    chk("init_busy_cycles", nb, 256);
    chk("init_done_pulses", nd, 1);

    foreach (vecs[k]) begin
      txn(vecs[k].which, vecs[k].we, vecs[k].adr, vecs[k].dat, 1'b0, 20, rd, lat, st_ok, extra);
      chk($sformatf("v%0d_latency", k), lat, vecs[k].lat);
      chk($sformatf("v%0d_stall", k), st_ok, 1);
      chk($sformatf("v%0d_extra_ack", k), extra, 0);
      if (vecs[k].we) begin
        chk($sformatf("v%0d_dat_hold", k), rd, last_rd[vecs[k].which]);
      end else begin
        chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp);
        last_rd[vecs[k].which] = vecs[k].exp;
      end
    end

    // Transaction wins over a same-cycle clear request; the clear follows.
    txn(0, 1, 8'h05, 8'h11, 1'b0, 20, rd, lat, st_ok, extra);
    chk("t5_wr_latency", lat, 2);
    txn(0, 0, 8'h05, 8'h00, 1'b1, 20, rd, lat, st_ok, extra);
    chk("t5_rd_latency", lat, 2);
    chk("t5_rd_before_clear", rd, 8'h11);
    chk("t5_busy_after", busy_a, 1);
    sweep_check(nb, nd);
    chk("t5_busy_cycles", nb, 256);
    chk("t5_done_pulses", nd, 1);
    txn(0, 0, 8'h05, 8'h00, 1'b0, 20, rd, lat, st_ok, extra);
    chk("t5_rd_after_clear", rd, 8'h00);

    // Request held through a whole sweep is served once the sweep ends.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("stalled_busy", busy_a, 1);
    txn(0, 0, 8'h06, 8'h00, 1'b0, 400, rd, lat, st_ok, extra);
    chk("stalled_latency", lat, 258);
    chk("stalled_rdata", rd, 8'h00);
    chk("stalled_extra_ack", extra, 0);
    repeat (5) tick();

    // Abort during wait states on DUT B.
    txn(1, 1, 8'h40, 8'h33, 1'b0, 20, rd, lat, st_ok, extra);
    chk("t6_wr_latency", lat, 4);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h40; dat_i = 8'h5A;
    ack_seen = 1'b0;
    tick();
    if (ack_b) ack_seen = 1'b1;
    tick();
    if (ack_b) ack_seen = 1'b1;
    chk("t6_stall_in_wait", stall_b, 1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    repeat (5) begin
      tick();
      if (ack_b) ack_seen = 1'b1;
    end
    chk("t6_abort_no_ack", ack_seen, 0);
    txn(1, 0, 8'h40, 8'h00, 1'b0, 20, rd, lat, st_ok, extra);
    chk("t6_mem_unchanged", rd, 8'h33);

    // Reset in the middle of a sweep restarts it from the first byte.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (50) tick();
    chk("t6_mid_sweep_busy", busy_a, 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_ack", ack_a, 0);
    chk("t6_rst_busy", busy_a, 1);
    rst = 1'b0;
    sweep_check(nb, nd);
    chk("t6_restart_busy_cycles", nb, 256);
    chk("t6_restart_done_pulses", nd, 1);
    txn(0, 0, 8'h00, 8'h00, 1'b0, 20, rd, lat, st_ok, extra);
    chk("final_rdata", rd, 8'h00);
    chk("final_latency", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
